// File: rtl/vend_pkg.sv
// Shared coin encodings, values and payout FSM state type for the vending coin interface.
package vend_pkg;

  localparam logic [3:0] COIN_FARTHING = 4'b0010;
  localparam logic [3:0] COIN_HAPENNY  = 4'b0100;
  localparam logic [3:0] COIN_PENNY    = 4'b1000;

  localparam int VAL_FARTHING = 1;
  localparam int VAL_HAPENNY  = 2;
  localparam int VAL_PENNY    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PRESENT,
    GAP,
    DONE,
    ERR
  } disp_state_t;

  function automatic logic [2:0] coin_value(input logic [3:0] coin);
    case (coin)
      COIN_PENNY:    return 3'(VAL_PENNY);
      COIN_HAPENNY:  return 3'(VAL_HAPENNY);
      COIN_FARTHING: return 3'(VAL_FARTHING);
      default:       return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy coin chooser. Define CHANGE_FALLBACK_EN to let an empty
// larger coin fall through to the next smaller one instead of failing.
module coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [3:0]       empty,
  output logic [3:0]       coin,
  output logic             none_ok
);

  localparam logic [AMT_W-1:0] REM_PENNY   = AMT_W'(VAL_PENNY);
  localparam logic [AMT_W-1:0] REM_HAPENNY = AMT_W'(VAL_HAPENNY);

  logic unused_empty0;
  assign unused_empty0 = empty[0];

  always_comb begin
    coin    = '0;
    none_ok = 1'b0;
`ifdef CHANGE_FALLBACK_EN
    if (remaining >= REM_PENNY && !empty[3]) begin
      coin = COIN_PENNY;
    end else if (remaining >= REM_HAPENNY && !empty[2]) begin
      coin = COIN_HAPENNY;
    end else if (remaining != '0 && !empty[1]) begin
      coin = COIN_FARTHING;
    end else begin
      none_ok = 1'b1;
    end
`else
    // Strict greedy: the coin is fixed by value alone; an empty tube is fatal.
    if (remaining >= REM_PENNY) begin
      if (!empty[3]) coin = COIN_PENNY;
      else           none_ok = 1'b1;
    end else if (remaining >= REM_HAPENNY) begin
      if (!empty[2]) coin = COIN_HAPENNY;
      else           none_ok = 1'b1;
    end else if (remaining != '0) begin
      if (!empty[1]) coin = COIN_FARTHING;
      else           none_ok = 1'b1;
    end else begin
      none_ok = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a farthing amount out as a sequence of hopper coin handshakes, largest coin first.
// Coin fallback on empty tubes is selected by CHANGE_FALLBACK_EN (see coin_select).
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [3:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ready,
  input  logic [3:0]       empty,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  disp_state_t      state_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [3:0]       sel_coin;
  logic             none_ok;
  logic [AMT_W-1:0] paid_next;

  coin_select #(.AMT_W(AMT_W)) u_select (
    .remaining (remaining),
    .empty     (empty),
    .coin      (sel_coin),
    .none_ok   (none_ok)
  );

  assign paid_next = remaining - AMT_W'(coin_value(coin_out));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      coin_out    <= '0;
      coin_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      remaining   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, ERR: begin
          if (start) begin
            err       <= 1'b0;
            busy      <= 1'b1;
            remaining <= amount;
            if (amount == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= SELECT;
            end
          end
        end
        SELECT: begin
          if (none_ok) begin
            state_reg <= ERR;
            err       <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state_reg  <= PRESENT;
            coin_out   <= sel_coin;
            coin_valid <= 1'b1;
          end
        end
        PRESENT: begin
          // coin_out stays frozen until the hopper takes it, whatever empty does meanwhile.
          if (coin_ready) begin
            coin_valid <= 1'b0;
            coin_out   <= '0;
            remaining  <= paid_next;
            if (paid_next == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg   <= GAP;
              gap_cnt_reg <= GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == '0) state_reg <= SELECT;
          else                   gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  no_underflow_a: assert property (@(posedge clk) disable iff (!res)
    (state_reg == PRESENT) |-> (remaining >= AMT_W'(coin_value(coin_out))));

endmodule
